midori_sbox_sched: RTL and testbench

Serial scheduler that pushes a 3-share (second-order masked) 64-bit Midori state through one shared, pipelined masked 4-bit S-box instance, one nibble per cycle. It owns the three share registers, handles the input and output valid/ready handshakes and the fresh-randomness handshake, and tracks in-flight nibbles through the S-box pipeline. It sits between the round datapath (ShuffleCell/MixColumn/key add) and the masked S-box.

---
 rtl/midori_sbox_sched_pkg.sv | 18 +
 rtl/midori_sbox_sched_share_nibble_rf.sv | 35 +++
 rtl/midori_sbox_sched.sv | 123 ++++++++++++
 tb/tb_midori_sbox_sched.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/midori_sbox_sched_pkg.sv
// Shared types and constants for the Midori masked S-box scheduler.
package midori_sbox_sched_pkg;

    localparam int NIB_N        = 16;
    localparam int NIB_W        = 4;
    localparam int SBOX_LAT_DEF = 3;
    localparam int RND_W_DEF    = 72;

    localparam logic [NIB_W-1:0] NIB_LAST = NIB_W'(NIB_N - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/midori_sbox_sched_share_nibble_rf.sv
// One 64-bit share register with a nibble read port, a nibble write port,
// parallel load and synchronous clear.
module share_nibble_rf
    import midori_sbox_sched_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [NIB_N*NIB_W-1:0] load_data,
    input  logic                   clr,
    input  logic [NIB_W-1:0]       rd_idx,
    output logic [NIB_W-1:0]       rd_data,
    input  logic                   wr_en,
    input  logic [NIB_W-1:0]       wr_idx,
    input  logic [NIB_W-1:0]       wr_data,
    output logic [NIB_N*NIB_W-1:0] q
);

    // NOTE: this register array is reset because a mid-operation reset must
    // not leave masked state behind; plain storage arrays normally are not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (clr) begin
            q <= '0;
        end else if (wr_en) begin
            q[wr_idx*NIB_W +: NIB_W] <= wr_data;
        end
    end

    assign rd_data = q[rd_idx*NIB_W +: NIB_W];

endmodule

// File: rtl/midori_sbox_sched.sv
// Serial scheduler feeding a 3-share Midori state through one pipelined masked
// S-box, one nibble per cycle. Define MIDORI_SCHED_CLR_EN to wipe the share
// registers after the result has been handed off.
module midori_sbox_sched
    import midori_sbox_sched_pkg::*;
#(
    parameter int SBOX_LAT = SBOX_LAT_DEF,
    parameter int RND_W    = RND_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_s1,
    input  logic [63:0]      in_s2,
    input  logic [63:0]      in_s3,
    input  logic             rnd_valid,
    output logic             rnd_ready,
    input  logic [RND_W-1:0] rnd,
    output logic [3:0]       sb_in1,
    output logic [3:0]       sb_in2,
    output logic [3:0]       sb_in3,
    output logic [RND_W-1:0] sb_rnd,
    input  logic [3:0]       sb_out1,
    input  logic [3:0]       sb_out2,
    input  logic [3:0]       sb_out3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_s1,
    output logic [63:0]      out_s2,
    output logic [63:0]      out_s3
);

    state_t              state, state_nxt;
    logic [NIB_W-1:0]    ic, rc;
    logic [SBOX_LAT-1:0] vld_sr;
    logic                load, issue, wb, clr;
    logic [NIB_W-1:0]    rd1, rd2, rd3;

    assign issue = rnd_ready && rnd_valid;
    assign wb    = vld_sr[SBOX_LAT-1];

`ifdef MIDORI_SCHED_CLR_EN
    assign clr = out_valid && out_ready;
`else
    assign clr = 1'b0;
`endif

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        rnd_ready = 1'b0;
        out_valid = 1'b0;
        load      = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                rnd_ready = 1'b1;
                if (rnd_valid && ic == NIB_LAST) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (wb && rc == NIB_LAST) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            ic     <= '0;
            rc     <= '0;
            vld_sr <= '0;
        end else begin
            state  <= state_nxt;
            vld_sr <= SBOX_LAT'({vld_sr, issue});
            if (load) begin
                ic <= '0;
                rc <= '0;
            end else begin
                if (issue) ic <= ic + 1'b1;
                if (wb)    rc <= rc + 1'b1;
            end
        end
    end

    // Each share has its own register and mux; shares never meet in here.
    share_nibble_rf u_rf1 (
        .clk(clk), .rst_n(rst_n), .load(load), .load_data(in_s1), .clr(clr),
        .rd_idx(ic), .rd_data(rd1), .wr_en(wb), .wr_idx(rc), .wr_data(sb_out1),
        .q(out_s1)
    );
    share_nibble_rf u_rf2 (
        .clk(clk), .rst_n(rst_n), .load(load), .load_data(in_s2), .clr(clr),
        .rd_idx(ic), .rd_data(rd2), .wr_en(wb), .wr_idx(rc), .wr_data(sb_out2),
        .q(out_s2)
    );
    share_nibble_rf u_rf3 (
        .clk(clk), .rst_n(rst_n), .load(load), .load_data(in_s3), .clr(clr),
        .rd_idx(ic), .rd_data(rd3), .wr_en(wb), .wr_idx(rc), .wr_data(sb_out3),
        .q(out_s3)
    );

    assign sb_in1 = issue ? rd1 : '0;
    assign sb_in2 = issue ? rd2 : '0;
    assign sb_in3 = issue ? rd3 : '0;
    assign sb_rnd = issue ? rnd : '0;

endmodule

// File: tb/tb_midori_sbox_sched.sv
// Directed self-checking bench for midori_sbox_sched with a 3-cycle masked
// Midori Sb0 model; honours MIDORI_SCHED_CLR_EN for the post-handshake check.
module tb_midori_sbox_sched;

    localparam int RND_W = 72;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_s1, in_s2, in_s3;
    logic             rnd_valid;
    logic             rnd_ready;
    logic [RND_W-1:0] rnd;
    logic [3:0]       sb_in1, sb_in2, sb_in3;
    logic [RND_W-1:0] sb_rnd;
    logic [3:0]       sb_out1, sb_out2, sb_out3;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_s1, out_s2, out_s3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    midori_sbox_sched dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_s1(in_s1), .in_s2(in_s2), .in_s3(in_s3),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd(rnd),
        .sb_in1(sb_in1), .sb_in2(sb_in2), .sb_in3(sb_in3), .sb_rnd(sb_rnd),
        .sb_out1(sb_out1), .sb_out2(sb_out2), .sb_out3(sb_out3),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_s1(out_s1), .out_s2(out_s2), .out_s3(out_s3)
    );

    function automatic logic [3:0] sb0(input logic [3:0] x);
        case (x)
            4'h0: sb0 = 4'hC;  4'h1: sb0 = 4'hA;  4'h2: sb0 = 4'hD;  4'h3: sb0 = 4'h3;
            4'h4: sb0 = 4'hE;  4'h5: sb0 = 4'hB;  4'h6: sb0 = 4'hF;  4'h7: sb0 = 4'h7;
            4'h8: sb0 = 4'h8;  4'h9: sb0 = 4'h9;  4'hA: sb0 = 4'h1;  4'hB: sb0 = 4'h5;
            4'hC: sb0 = 4'h0;  4'hD: sb0 = 4'h2;  4'hE: sb0 = 4'h4;  default: sb0 = 4'h6;
        endcase
    endfunction

    function automatic logic [63:0] sb0_64(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 16; i++) y[4*i +: 4] = sb0(x[4*i +: 4]);
        return y;
    endfunction

    // Behavioural masked S-box: re-shares Sb0(x) with two fresh mask nibbles.
    logic [11:0] pipe [3];
    logic [3:0]  m_a, m_b;
    assign m_a = sb_rnd[3:0];
    assign m_b = sb_rnd[7:4];
    always @(posedge clk) begin
        pipe[0] <= {sb0(sb_in1 ^ sb_in2 ^ sb_in3) ^ m_a ^ m_b, m_a, m_b};
        pipe[1] <= pipe[0];
        pipe[2] <= pipe[1];
    end
    assign {sb_out1, sb_out2, sb_out3} = pipe[2];

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"},  in_ready, 1);
        check({tag, "_rnd_ready"}, rnd_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_sb_in"},     {sb_in1, sb_in2, sb_in3}, 0);
        check({tag, "_sb_rnd"},    sb_rnd, 0);
        check({tag, "_out_s1"},    out_s1, 0);
        check({tag, "_out_s2"},    out_s2, 0);
        check({tag, "_out_s3"},    out_s3, 0);
    endtask

    // Loads a state, feeds randomness (with an optional gap once gap_after
    // nibbles are issued) and returns at posedge+2 of the first DONE cycle.
    task automatic run_op(input logic [63:0] s1, input logic [63:0] s2,
                          input logic [63:0] s3, input int gap_after,
                          input int gap_len, input bit junk);
        int k, g, lat, rr, w;
        logic [95:0] r96;
        logic        rv;
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #2;
            w++;
        end
        check("in_ready_before_load", in_ready, 1);
        in_s1 = s1; in_s2 = s2; in_s3 = s3;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = junk;
        if (junk) begin
            in_s1 = ~s1; in_s2 = s2 ^ 64'h5A5A; in_s3 = 64'h0;
        end
        lat = -1; rr = 0; k = 0; g = 0;
        for (int n = 1; n <= 60; n++) begin
            rv = !(k == gap_after && g < gap_len);
            r96 = {$urandom, $urandom, $urandom};
            rnd_valid = rv;
            rnd = r96[71:0];
            #1;
            if (out_valid) begin
                lat = n;
                break;
            end
            if (n == 1) check("in_ready_busy", in_ready, 0);
            if (rnd_ready) rr++;
            if (rnd_ready && rv) begin
                check("sb_in1_nib", sb_in1, s1[4*k +: 4]);
                check("sb_in2_nib", sb_in2, s2[4*k +: 4]);
                check("sb_in3_nib", sb_in3, s3[4*k +: 4]);
                check("sb_rnd_fwd", sb_rnd, rnd);
                k++;
            end else if (rnd_ready) begin
                check("bubble_sb_in", {sb_in1, sb_in2, sb_in3}, 0);
                check("bubble_sb_rnd", sb_rnd, 0);
                g++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rnd_valid = 1'b1;
        check("latency", lat, 20 + gap_len);
        check("rnd_ready_cycles", rr, 16 + gap_len);
    endtask

    // Checks the result, holds out_ready low for `hold` cycles, completes the
    // handshake and checks the IDLE cycle that follows. Ends at posedge+2.
    task automatic finish_op(input logic [63:0] exp_plain, input int hold);
        logic [63:0] o1, o2, o3;
        check("result", out_s1 ^ out_s2 ^ out_s3, exp_plain);
        o1 = out_s1; o2 = out_s2; o3 = out_s3;
        for (int i = 0; i < hold; i++) begin
            check("hold_out_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_stable", {out_s1, out_s2, out_s3} === {o1, o2, o3}, 1);
            @(posedge clk); #2;
        end
        out_ready = 1'b1;
        check("done_out_valid", out_valid, 1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        #1;
        check("post_hs_in_ready", in_ready, 1);
        check("post_hs_out_valid", out_valid, 0);
`ifdef MIDORI_SCHED_CLR_EN
        check("clr_out_s1", out_s1, 0);
        check("clr_out_s2", out_s2, 0);
        check("clr_out_s3", out_s3, 0);
`else
        check("keep_result", out_s1 ^ out_s2 ^ out_s3, exp_plain);
        check("keep_s1", out_s1, o1);
`endif
    endtask

    initial begin
        logic [63:0] a, b, p;
        int ga, gl;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; rnd_valid = 1'b0;
        in_s1 = '0; in_s2 = '0; in_s3 = '0; rnd = '0;
        repeat (3) @(posedge clk);
        #2;
        check_reset_vals("rst");
        rst_n = 1'b1;
        @(posedge clk); #2;
        check_reset_vals("idle");
        rnd_valid = 1'b1;

        // Continuous flow.
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        run_op(a, b, 64'h0123456789ABCDEF ^ a ^ b, -1, 0, 1'b0);
        finish_op(64'hCAD3EBF789150246, 0);

        // Randomness starvation: 5 bubbles after nibble 7.
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        run_op(a, b, 64'h0123456789ABCDEF ^ a ^ b, 8, 5, 1'b0);
        finish_op(64'hCAD3EBF789150246, 0);

        // Backpressure, plus in_valid held high with junk while busy.
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        run_op(a, b, 64'hFEDCBA9876543210 ^ a ^ b, -1, 0, 1'b1);
        finish_op(64'h642051987FBE3DAC, 10);

        // Immediate back-to-back load, then reset after nibble 5.
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        in_s1 = a; in_s2 = b; in_s3 = 64'h1111 ^ a ^ b;
        check("b2b_in_ready", in_ready, 1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_rst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        run_op(a, b, 64'h0123456789ABCDEF ^ a ^ b, -1, 0, 1'b0);
        finish_op(64'hCAD3EBF789150246, 0);

        // Share isolation: fixed plaintext, fresh masks and random gaps.
        p = 64'h0011223344556677;
        for (int r = 0; r < 100; r++) begin
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            ga = $urandom_range(0, 15);
            gl = $urandom_range(0, 3);
            run_op(p ^ a ^ b, a, b, ga, gl, 1'b0);
            finish_op(sb0_64(p), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
